// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson counter with direction, clock enable, parallel load,
// illegal-state detection with optional self-correction, a binary step index and a wrap pulse.
module ring_counter_param #(
  parameter int WIDTH        = 4,
  parameter int MODE         = 0,
  parameter int SELF_CORRECT = 1,
  parameter int IDX_W        = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [IDX_W-1:0] step,
  output logic             illegal,
  output logic             wrap
);

  localparam int               PERIOD      = (MODE == 1) ? 2 * WIDTH : WIDTH;
  localparam logic [WIDTH-1:0] RESET_STATE = (MODE == 1) ? '0 : WIDTH'(1);

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic             w_legal;
  logic [IDX_W-1:0] w_step;
  logic [WIDTH-1:0] w_shift;
  logic             w_wrap_next;

  // Mask with bits [k-1:0] set; k == WIDTH yields all ones.
  function automatic logic [WIDTH-1:0] low_mask(input int k);
    return ~({WIDTH{1'b1}} << k);
  endfunction

  // Legality check and step decode of the current state.
  // NOTE: every variable gets a default before the loops so no path leaves one unassigned (no latch).
  always_comb begin
    w_legal = 1'b0;
    w_step  = '0;
    if (MODE == 1) begin
      for (int k = 0; k <= WIDTH; k++) begin
        if (r_out == low_mask(k)) begin
          w_legal = 1'b1;
          w_step  = IDX_W'(k);
        end
        if (k >= 1 && k <= WIDTH - 1 && r_out == ~low_mask(k)) begin
          w_legal = 1'b1;
          w_step  = IDX_W'(WIDTH + k);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_out == (WIDTH'(1) << i)) begin
          w_legal = 1'b1;
          w_step  = IDX_W'(i);
        end
      end
    end
  end

  // Johnson inverts the bit fed back around the ring; ring mode feeds it back unchanged.
  always_comb begin
    w_shift = r_out;
    if (dir) begin
      w_shift = {((MODE == 1) ? ~r_out[0] : r_out[0]), r_out[WIDTH-1:1]};
    end else begin
      w_shift = {r_out[WIDTH-2:0], ((MODE == 1) ? ~r_out[WIDTH-1] : r_out[WIDTH-1])};
    end
  end

  assign w_wrap_next = w_legal && (dir ? (w_step == '0) : (w_step == IDX_W'(PERIOD - 1)));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= RESET_STATE;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_out  <= load_val;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (!w_legal && SELF_CORRECT != 0) begin
        r_out  <= RESET_STATE;
        r_wrap <= 1'b0;
      end else begin
        r_out  <= w_shift;
        r_wrap <= w_wrap_next;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign out     = r_out;
  assign step    = w_step;
  assign illegal = ~w_legal;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_ring_counter_param.sv
// Scoreboard bench for ring_counter_param: three instances (ring+correct, Johnson+correct,
// ring without correction) driven one at a time; a monitor pops expectations after each edge.
module tb_ring_counter_param;

  localparam int W  = 4;
  localparam int IW = 6;

  typedef struct {
    int          unit;
    logic [W-1:0] out;
    int          step;
    logic        ill;
    logic        wrap;
    string       name;
  } exp_t;

  logic         clk;
  logic [2:0]   rst, en, dir, load;
  logic [W-1:0] lv    [3];
  logic [W-1:0] out   [3];
  logic [IW-1:0] step [3];
  logic [2:0]   ill, wrp;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  ring_counter_param #(.WIDTH(W), .MODE(0), .SELF_CORRECT(1), .IDX_W(IW)) u_ring (
    .clk(clk), .rst(rst[0]), .en(en[0]), .dir(dir[0]), .load(load[0]), .load_val(lv[0]),
    .out(out[0]), .step(step[0]), .illegal(ill[0]), .wrap(wrp[0]));

  ring_counter_param #(.WIDTH(W), .MODE(1), .SELF_CORRECT(1), .IDX_W(IW)) u_john (
    .clk(clk), .rst(rst[1]), .en(en[1]), .dir(dir[1]), .load(load[1]), .load_val(lv[1]),
    .out(out[1]), .step(step[1]), .illegal(ill[1]), .wrap(wrp[1]));

  ring_counter_param #(.WIDTH(W), .MODE(0), .SELF_CORRECT(0), .IDX_W(IW)) u_nocorr (
    .clk(clk), .rst(rst[2]), .en(en[2]), .dir(dir[2]), .load(load[2]), .load_val(lv[2]),
    .out(out[2]), .step(step[2]), .illegal(ill[2]), .wrap(wrp[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Apply one cycle of stimulus to unit u and queue the state expected after the next edge.
  task automatic drive(input int u, input logic r, input logic e, input logic d, input logic l,
                       input logic [W-1:0] v, input logic [W-1:0] eo, input int es,
                       input logic ei, input logic ew, input string nm);
    exp_t x;
    @(negedge clk);
    rst[u] = r; en[u] = e; dir[u] = d; load[u] = l; lv[u] = v;
    x.unit = u; x.out = eo; x.step = es; x.ill = ei; x.wrap = ew; x.name = nm;
    q.push_back(x);
  endtask

  // Monitor: one expectation is consumed per clock edge, sampled 1 time unit after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check({x.name, " out"},     32'(out[x.unit]),  32'(x.out));
        check({x.name, " step"},    32'(step[x.unit]), 32'(x.step));
        check({x.name, " illegal"}, 32'(ill[x.unit]),  32'(x.ill));
        check({x.name, " wrap"},    32'(wrp[x.unit]),  32'(x.wrap));
      end
    end
  end

  initial begin
    rst = '1; en = '0; dir = '0; load = '0;
    for (int i = 0; i < 3; i++) lv[i] = '0;

    // ---- unit 0: ring, self-correcting ----
    drive(0, 1, 0, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r0 reset");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0010, 1, 0, 0, "r0 fwd1");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0100, 2, 0, 0, "r0 fwd2");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b1000, 3, 0, 0, "r0 fwd3");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 1, "r0 fwd wrap");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0010, 1, 0, 0, "r0 fwd after wrap");
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 0, 0, 4'h0, 4'b0010, 1, 0, 0, "r0 hold");
    drive(0, 1, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r0 reset midseq");
    #1;
    check("r0 no effect before edge out", 32'(out[0]), 32'(4'b0010));
    drive(0, 0, 1, 1, 0, 4'h0, 4'b1000, 3, 0, 1, "r0 bwd wrap");
    drive(0, 0, 1, 1, 0, 4'h0, 4'b0100, 2, 0, 0, "r0 bwd");
    drive(0, 0, 1, 0, 1, 4'b0100, 4'b0100, 2, 0, 0, "r0 load beats en");
    drive(0, 1, 0, 0, 1, 4'b1000, 4'b0001, 0, 0, 0, "r0 rst beats load");
    drive(0, 0, 0, 0, 1, 4'b0110, 4'b0110, 0, 1, 0, "r0 load illegal");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r0 correct");
    drive(0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, "r0 load zero");
    drive(0, 0, 1, 1, 0, 4'h0, 4'b0001, 0, 0, 0, "r0 correct bwd no wrap");
    drive(0, 0, 0, 0, 1, 4'b1000, 4'b1000, 3, 0, 0, "r0 load last");
    drive(0, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 1, "r0 wrap from load");
    drive(0, 0, 0, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "r0 idle");

    // ---- unit 1: Johnson, self-correcting ----
    drive(1, 1, 0, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "j1 reset");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0001, 1, 0, 0, "j1 f1");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0011, 2, 0, 0, "j1 f2");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0111, 3, 0, 0, "j1 f3");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b1111, 4, 0, 0, "j1 f4");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b1110, 5, 0, 0, "j1 f5");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b1100, 6, 0, 0, "j1 f6");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b1000, 7, 0, 0, "j1 f7");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0000, 0, 0, 1, "j1 f wrap");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0001, 1, 0, 0, "j1 f9");
    drive(1, 1, 1, 1, 0, 4'h0, 4'b0000, 0, 0, 0, "j1 reset2");
    drive(1, 0, 1, 1, 0, 4'h0, 4'b1000, 7, 0, 1, "j1 bwd wrap");
    drive(1, 0, 1, 1, 0, 4'h0, 4'b1100, 6, 0, 0, "j1 b2");
    drive(1, 0, 1, 1, 0, 4'h0, 4'b1110, 5, 0, 0, "j1 b3");
    drive(1, 0, 1, 1, 0, 4'h0, 4'b1111, 4, 0, 0, "j1 b4");
    drive(1, 0, 0, 0, 1, 4'b0101, 4'b0101, 0, 1, 0, "j1 load illegal");
    drive(1, 0, 1, 0, 0, 4'h0, 4'b0000, 0, 0, 0, "j1 correct");
    drive(1, 0, 0, 0, 1, 4'b1110, 4'b1110, 5, 0, 0, "j1 load legal");
    drive(1, 0, 0, 0, 0, 4'h0, 4'b1110, 5, 0, 0, "j1 idle");

    // ---- unit 2: ring, no self-correction ----
    drive(2, 1, 0, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "n2 reset");
    drive(2, 0, 0, 0, 1, 4'b0110, 4'b0110, 0, 1, 0, "n2 load illegal");
    drive(2, 0, 1, 0, 0, 4'h0, 4'b1100, 0, 1, 0, "n2 rotate1");
    drive(2, 0, 1, 0, 0, 4'h0, 4'b1001, 0, 1, 0, "n2 rotate2");
    drive(2, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 1, 0, "n2 load zero");
    drive(2, 0, 1, 0, 0, 4'h0, 4'b0000, 0, 1, 0, "n2 zero fwd");
    drive(2, 0, 1, 1, 0, 4'h0, 4'b0000, 0, 1, 0, "n2 zero bwd");
    drive(2, 0, 0, 0, 1, 4'b1000, 4'b1000, 3, 0, 0, "n2 load last");
    drive(2, 0, 1, 0, 0, 4'h0, 4'b0001, 0, 0, 1, "n2 wrap");
    drive(2, 0, 0, 0, 0, 4'h0, 4'b0001, 0, 0, 0, "n2 idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) check("scoreboard drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
